// File: rtl/decode_pkg.sv
// Shared types and constants for the decode-stage control generator.
package decode_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_LDR = 3'b100;
  localparam logic [2:0] OP_STR = 3'b101;
  localparam logic [2:0] OP_B   = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Width of the squash-window counter; KILL_DEPTH tops out at 3.
  localparam int KILL_W = 2;

  // Everything the execute stage needs from decode.
  typedef struct packed {
    logic [2:0] opcode;
    logic       v;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] alu_control;
  } ctrl_t;

  // A bubble looks like a NOP with every enable and select cleared.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({OP_NOP, 10'b0});

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder: OpcodeD/VD -> ctrl_t.
// Optional feature macro: DECODE_VECTOR_EN (carry VD into the control word
// and suppress scalar flag writes for vector ops).
module control_decoder
  import decode_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       vd,
  output ctrl_t      ctrl
);

`ifndef DECODE_VECTOR_EN
  // VD has no effect without vector support.
  logic unused_vd;
  assign unused_vd = vd;
`endif

  // Map the opcode to its control fields; unused fields stay at bubble values.
  always_comb begin
    ctrl        = CTRL_BUBBLE;
    ctrl.opcode = opcode;
    case (opcode)
      OP_ADD: begin
        ctrl.regw        = 1'b1;
        ctrl.alu_control = ALU_ADD;
        ctrl.flagw       = 2'b11;
      end
      OP_SUB: begin
        ctrl.regw        = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.flagw       = 2'b11;
      end
      OP_CMP: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.flagw       = 2'b11;
      end
      OP_BEQ: begin
        ctrl.pcs = 1'b1;
      end
      OP_LDR: begin
        ctrl.regw     = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_STR: begin
        ctrl.memw   = 1'b1;
        ctrl.alusrc = 1'b1;
      end
      OP_B: begin
        ctrl.pcs = 1'b1;
      end
      default: begin
        ctrl = CTRL_BUBBLE;
      end
    endcase
`ifdef DECODE_VECTOR_EN
    ctrl.v = vd;
    if (vd) ctrl.flagw = 2'b00;
`endif
  end

endmodule

// File: rtl/decode_control_unit.sv
// Decode-stage control generator with the D->E control pipeline register.
// Inserts bubbles on flush and for KILL_DEPTH cycles after a taken branch.
// Optional feature macro: DECODE_VECTOR_EN (see control_decoder).
module decode_control_unit
  import decode_pkg::*;
#(
  parameter int unsigned KILL_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] OpcodeD,
  input  logic       VD,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcE,
  output logic [2:0] OpcodeE,
  output logic       VE,
  output logic       PCSE,
  output logic       RegWE,
  output logic       MemWE,
  output logic [1:0] FlagWE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [1:0] ALUControlE,
  output logic       KillActive
);

  localparam logic [KILL_W-1:0] KILL_LOAD = KILL_W'(KILL_DEPTH);

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_nxt;
  logic [KILL_W-1:0] kill_cnt;
  logic [KILL_W-1:0] kill_nxt;

  control_decoder u_dec (
    .opcode (OpcodeD),
    .vd     (VD),
    .ctrl   (ctrl_d)
  );

  // Next E word and squash count, in strict priority order.
  always_comb begin
    ctrl_nxt = ctrl_q;
    kill_nxt = kill_cnt;
    if (PCSrcE) begin
      ctrl_nxt = CTRL_BUBBLE;
      kill_nxt = KILL_LOAD;
    end else if (FlushE) begin
      ctrl_nxt = CTRL_BUBBLE;
    end else if ((kill_cnt != '0) && !StallE) begin
      ctrl_nxt = CTRL_BUBBLE;
      kill_nxt = kill_cnt - 1'b1;
    end else if (!StallE) begin
      ctrl_nxt = ctrl_d;
    end
  end

  // E control register and squash counter; reset forces a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= CTRL_BUBBLE;
      kill_cnt <= '0;
    end else begin
      ctrl_q   <= ctrl_nxt;
      kill_cnt <= kill_nxt;
    end
  end

  assign OpcodeE     = ctrl_q.opcode;
  assign VE          = ctrl_q.v;
  assign PCSE        = ctrl_q.pcs;
  assign RegWE       = ctrl_q.regw;
  assign MemWE       = ctrl_q.memw;
  assign FlagWE      = ctrl_q.flagw;
  assign MemtoRegE   = ctrl_q.memtoreg;
  assign ALUSrcE     = ctrl_q.alusrc;
  assign ALUControlE = ctrl_q.alu_control;
  assign KillActive  = (kill_cnt != '0);

endmodule

// File: doc/decode_control_unit.md
# decode_control_unit

Decode-stage control generator and D→E control pipeline register. It produces the `PCS`/`RegW`/`MemW`/`FlagW` control word and the `Opcode`/`V` pair that the execute-stage conditional unit consumes. The block inserts bubbles on hazard flush and on a taken branch, so that wrong-path instructions never reach the conditional unit with write enables set.

## Interface
Parameters:
- `KILL_DEPTH`, default 1: number of extra wrong-path instructions squashed after a taken branch. Legal range 0–3.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assertion, active-low (reset while `rst`=0).
- `OpcodeD`  in  3  opcode of the instruction in decode.
- `VD`  in  1  vector bit of the instruction in decode.
- `StallE`  in  1  hold the E control register.
- `FlushE`  in  1  load a bubble into E.
- `PCSrcE`  in  1  taken-branch indication from the conditional unit.
- `OpcodeE`  out  3  to conditional unit `Opcode`.
- `VE`  out  1  to conditional unit `V`.
- `PCSE`, `RegWE`, `MemWE`  out  1 each  to conditional unit `PCS`/`RegW`/`MemW`.
- `FlagWE`  out  2  flag-write enables: bit1 for NZ, bit0 for CV.
- `MemtoRegE`, `ALUSrcE`  out  1 each  datapath selects.
- `ALUControlE`  out  2  ALU operation: 00 ADD, 01 SUB.
- `KillActive`  out  1  high while the squash window is open.

## Operation
Opcode decode: PCS, RegW, MemW, MemtoReg, ALUSrc, ALUControl, FlagW.
- 000 ADD: 0,1,0,0,0,00,11
- 001 SUB: 0,1,0,0,0,01,11
- 010 CMP: 0,0,0,0,0,01,11
- 011 BEQ: 1,0,0,0,0,00,00
- 100 LDR: 0,1,0,1,1,00,00
- 101 STR: 0,0,1,0,1,00,00
- 110 B: 1,0,0,0,0,00,00
- 111 NOP: all 0

Bubble definition:
- `OpcodeE`=111, `VE`=0.
- All enables and selects 0.

Register update priority on each edge:
1. `rst` low.
2. `PCSrcE`=1: load a bubble and set `kill_cnt`=`KILL_DEPTH`.
3. `FlushE`=1: load a bubble.
4. `kill_cnt`≠0 and `StallE`=0: load a bubble and decrement `kill_cnt`.
5. `StallE`=1: hold the register; `kill_cnt` is also held.
6. Otherwise: load the decode of `OpcodeD`/`VD`.

Squash window:
- `KillActive` = (`kill_cnt`≠0).
- If `PCSrcE` asserts while the window is open, the counter reloads to `KILL_DEPTH`; it does not accumulate.
- `KILL_DEPTH`=0: only the instruction currently in D is squashed.

## Timing
- Latency: decode fields appear on the E outputs one cycle after `OpcodeD` is sampled.
- Reset values: every output is at bubble values (`OpcodeE`=111, all others 0), `kill_cnt`=0, `KillActive`=0.
- Reset asserted mid-window clears `kill_cnt` immediately (asynchronous).
- The squash bubble is loaded on the same edge that samples `PCSrcE`=1.
- `FlushE` and `StallE` both high: flush wins.
- `PCSrcE` and `StallE` both high: the squash wins.
- The block adds no combinational path from inputs to outputs; all outputs are registered.

## Configuration
Macro: `DECODE_VECTOR_EN`.
- Defined:
  - `VD` is registered into `VE`.
  - When `VD`=1, `FlagWE` is forced to 00 (vector ops never update scalar flags).
- Undefined:
  - `VD` is ignored and `VE` is constant 0.
  - `FlagWE` follows the decode only.

## Structure
Shared package `decode_pkg`:
- Opcode localparams `OP_ADD` … `OP_NOP`.
- `ALU_ADD`/`ALU_SUB` constants.
- Packed struct `ctrl_t` holding all E control fields.
- Constant `CTRL_BUBBLE`.

One combinational sub-module, `control_decoder`:
- Maps `OpcodeD`/`VD` to `ctrl_t`.
- `decode_control_unit` holds the `ctrl_t` register and `kill_cnt`.

## Test plan
- **Reset:** `rst`=0 asynchronously mid-cycle → outputs immediately at bubble values (`OpcodeE`=111), `KillActive`=0.
- **Decode sweep:** `OpcodeD` 000–111 on consecutive cycles, no stall/flush → each E word matches the decode list one cycle later, e.g. 100 → `RegWE`=1, `MemtoRegE`=1, `ALUSrcE`=1.
- **Taken branch:**
  - Stimulus: `OpcodeD`=000 in D while `PCSrcE`=1, `KILL_DEPTH`=1.
  - Response: E is a bubble for 2 consecutive cycles with `KillActive`=1 for one cycle; the third instruction passes through.
- **Stall inside window:** `StallE`=1 for 3 cycles during the window → bubble held, `kill_cnt` held at 1; after release, one more bubble, then normal loads.
- **Priority:** `FlushE`=1 with `StallE`=1 → bubble loaded. `PCSrcE`=1 with `StallE`=1 → bubble loaded and `kill_cnt`=`KILL_DEPTH`.
- **Vector (`DECODE_VECTOR_EN` defined):** `OpcodeD`=001, `VD`=1 → `VE`=1, `FlagWE`=00, `RegWE`=1. With the macro undefined, the same stimulus gives `VE`=0, `FlagWE`=11.
